// File: rtl/retire_trace_fifo.sv
// Retire trace FIFO: buffers WB retire records with sequence numbers and drop/gap tracking.
// Optional memory fields per record are enabled with RETIRE_TRACE_MEM_EN.
module retire_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_retired,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rd_data,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_write,
`ifdef RETIRE_TRACE_MEM_EN
  input  logic             in_mem_valid,
  input  logic [31:0]      in_mem_addr,
  input  logic [31:0]      in_mem_wdata,
  output logic             out_mem_valid,
  output logic [31:0]      out_mem_addr,
  output logic [31:0]      out_mem_wdata,
`endif
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_rd_data,
  output logic [4:0]       out_rd,
  output logic             out_rd_write,
  output logic [31:0]      out_seq,
  output logic             out_gap,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic [15:0]      drop_count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rd_data;
    logic [4:0]  rd;
    logic        rd_write;
    logic [31:0] seq;
    logic        gap;
`ifdef RETIRE_TRACE_MEM_EN
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
`endif
  } rec_t;

  rec_t             r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [LVL_W-1:0] r_level;
  logic [15:0]      r_drop;
  logic [31:0]      r_seq;
  logic             r_gap;

  logic w_full;
  logic w_nonempty;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_take;
  rec_t w_rec;
  rec_t w_head;

  assign w_full     = (r_level == LVL_W'(DEPTH));
  assign w_nonempty = (r_level != '0);
  // flush wins over everything in its cycle
  assign w_take     = in_retired && !flush;
  assign w_pop      = w_nonempty && out_ready && !flush;
  assign w_push     = w_take && (!w_full || w_pop);
  assign w_drop     = w_take && w_full && !w_pop;

  always_comb begin
    w_rec          = '0;
    w_rec.pc       = in_pc;
    w_rec.instr    = in_instr;
    w_rec.rd_data  = in_rd_data;
    w_rec.rd       = in_rd;
    w_rec.rd_write = in_rd_write;
    w_rec.seq      = r_seq;
    w_rec.gap      = r_gap;
`ifdef RETIRE_TRACE_MEM_EN
    w_rec.mem_valid = in_mem_valid;
    w_rec.mem_addr  = in_mem_addr;
    w_rec.mem_wdata = in_mem_wdata;
`endif
  end

  // storage is left unreset; only pointers and flags reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop)
        r_level <= r_level + LVL_W'(1);
      else if (w_pop && !w_push)
        r_level <= r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq  <= '0;
      r_gap  <= 1'b0;
      r_drop <= '0;
    end else begin
      if (w_take) r_seq <= r_seq + 32'd1;
      if (w_drop) r_gap <= 1'b1;
      else if (w_push) r_gap <= 1'b0;
      if (w_drop && r_drop != 16'hFFFF)
        r_drop <= r_drop + 16'd1;
    end
  end

  assign w_head       = r_mem[r_rp];
  assign out_valid    = w_nonempty;
  assign out_pc       = w_head.pc;
  assign out_instr    = w_head.instr;
  assign out_rd_data  = w_head.rd_data;
  assign out_rd       = w_head.rd;
  assign out_rd_write = w_head.rd_write;
  assign out_seq      = w_head.seq;
  assign out_gap      = w_head.gap;
`ifdef RETIRE_TRACE_MEM_EN
  assign out_mem_valid = w_head.mem_valid;
  assign out_mem_addr  = w_head.mem_addr;
  assign out_mem_wdata = w_head.mem_wdata;
`endif
  assign level        = r_level;
  assign full         = w_full;
  assign drop_count   = r_drop;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Directed self-checking bench for retire_trace_fifo (DEPTH=16).
// Covers FWFT latency, drop/gap, full push+pop, flush, async reset, saturation.
module tb_retire_trace_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_retired;
  logic [31:0] in_pc, in_instr, in_rd_data;
  logic [4:0]  in_rd;
  logic        in_rd_write;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_instr, out_rd_data;
  logic [4:0]  out_rd;
  logic        out_rd_write;
  logic [31:0] out_seq;
  logic        out_gap;
  logic [4:0]  level;
  logic        full;
  logic [15:0] drop_count;
`ifdef RETIRE_TRACE_MEM_EN
  logic        in_mem_valid = 1'b0;
  logic [31:0] in_mem_addr = '0, in_mem_wdata = '0;
  logic        out_mem_valid;
  logic [31:0] out_mem_addr, out_mem_wdata;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  retire_trace_fifo #(.DEPTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_retired(in_retired), .in_pc(in_pc),
    .in_instr(in_instr), .in_rd_data(in_rd_data),
    .in_rd(in_rd), .in_rd_write(in_rd_write),
`ifdef RETIRE_TRACE_MEM_EN
    .in_mem_valid(in_mem_valid), .in_mem_addr(in_mem_addr),
    .in_mem_wdata(in_mem_wdata), .out_mem_valid(out_mem_valid),
    .out_mem_addr(out_mem_addr), .out_mem_wdata(out_mem_wdata),
`endif
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .out_rd_data(out_rd_data), .out_rd(out_rd),
    .out_rd_write(out_rd_write), .out_seq(out_seq),
    .out_gap(out_gap), .level(level), .full(full),
    .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc);
    in_pc       = pc;
    in_instr    = ~pc;
    in_rd_data  = pc ^ 32'h5A5A_A5A5;
    in_rd       = pc[6:2];
    in_rd_write = pc[2];
  endtask

  task automatic retire(input logic [31:0] pc);
    drive(pc);
    in_retired = 1'b1;
    tick();
    in_retired = 1'b0;
  endtask

  task automatic drain(input int n, input int seq0,
                       input logic [31:0] pc0, input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_seq"}, out_seq, 32'(seq0 + i));
      chk({tag, "_gap"}, 32'(out_gap), 32'd0);
      chk({tag, "_pc"}, out_pc, pc0 + 32'(4 * i));
      tick();
    end
    out_ready = 1'b0;
    chk({tag, "_empty"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_retired = 1'b0; flush = 1'b0;
    out_ready = 1'b0; drive(32'h0);
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // first push visible one cycle later, held while not ready
    retire(32'h8000_0000);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_pc", out_pc, 32'h8000_0000);
    chk("first_seq", out_seq, 32'd0);
    chk("first_level", 32'(level), 32'd1);
    chk("first_instr", out_instr, 32'h7FFF_FFFF);
    chk("first_rdd", out_rd_data, 32'hDA5A_A5A5);
    tick(); tick(); tick();
    chk("hold_pc", out_pc, 32'h8000_0000);
    chk("hold_valid", 32'(out_valid), 32'd1);

    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

    // 18 retires into 16 entries: two drops
    for (int i = 0; i < 18; i++) retire(32'h1000 + 32'(4 * i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_drop", 32'(drop_count), 32'd2);
    drain(16, 0, 32'h1000, "d0");

    retire(32'h2000);
    chk("gap_seq", out_seq, 32'd18);
    chk("gap_flag", 32'(out_gap), 32'd1);
    chk("gap_rd", 32'(out_rd), 32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    retire(32'h2004);
    chk("nogap_seq", out_seq, 32'd19);
    chk("nogap_flag", 32'(out_gap), 32'd0);
    chk("nogap_rdw", 32'(out_rd_write), 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++) retire(32'h3000 + 32'(4 * i));
    chk("f2_full", 32'(full), 32'd1);
    drive(32'h3040);
    in_retired = 1'b1; out_ready = 1'b1;
    tick();
    in_retired = 1'b0; out_ready = 1'b0;
    chk("pp_level", 32'(level), 32'd16);
    chk("pp_drop", 32'(drop_count), 32'd2);
    chk("pp_head", out_seq, 32'd21);
    drain(16, 21, 32'h3004, "d1");

    // flush with a same-cycle retire
    for (int i = 0; i < 5; i++) retire(32'h4000 + 32'(4 * i));
    chk("fl_level5", 32'(level), 32'd5);
    drive(32'h4100);
    in_retired = 1'b1; flush = 1'b1;
    tick();
    in_retired = 1'b0; flush = 1'b0;
    chk("fl_level", 32'(level), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_drop", 32'(drop_count), 32'd2);
    retire(32'h4200);
    chk("fl_seq", out_seq, 32'd42);
    chk("fl_pc", out_pc, 32'h4200);

    // async reset mid-stream at level 7
    for (int i = 0; i < 6; i++) retire(32'h5000 + 32'(4 * i));
    chk("ar_level7", 32'(level), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_level", 32'(level), 32'd0);
    chk("ar_drop", 32'(drop_count), 32'd0);
    tick(); rst_n = 1'b1; tick();
    retire(32'h6000);
    chk("ar_seq", out_seq, 32'd0);
    chk("ar_gap", 32'(out_gap), 32'd0);

    // drop counter saturation
    for (int i = 1; i < 16; i++) retire(32'h6000 + 32'(4 * i));
    drive(32'h7000);
    in_retired = 1'b1;
    repeat (65536) tick();
    in_retired = 1'b0;
    chk("sat_drop", 32'(drop_count), 32'hFFFF);
    chk("sat_level", 32'(level), 32'd16);
    drain(16, 0, 32'h6000, "d2");
    retire(32'h7100);
    chk("sat_seq", out_seq, 32'h0001_0010);
    chk("sat_gap", 32'(out_gap), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
